div_seq_32: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned integer divider for the CPU datapath (DIV/DIVU).

---
 rtl/div_seq_32_pkg.sv | 28 ++
 rtl/div_seq_32_add.sv | 42 ++++
 rtl/div_seq_32.sv | 200 ++++++++++++++++++++
 tb/tb_div_seq_32.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential 32-bit divider: widths, FSM state
// encoding, divide-by-zero result constant and the result payload struct.
package div_seq_32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ITERS  = 32;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIX_Q = 3'd4,
    ST_FIX_R = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Result payload presented on HI/LO
  typedef struct packed {
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic              dbz;
  } div_res_t;

endpackage

// File: rtl/div_seq_32_add.sv
// 32-bit carry-lookahead adder (4-bit lookahead groups, group carries chained).
// No carry-in; negation is done by callers as (~x) + 1.
//   a_i, b_i : operands
//   rc_o     : sum
//   c_out_o  : carry out of bit 31
module div_seq_32_add
  import div_seq_32_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] rc_o,
  output logic              c_out_o
);

  localparam int unsigned GROUPS = DATA_W / 4;

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] c;
  logic [GROUPS:0]   gc;

  // Per-group lookahead; gc[k] is the carry into group k
  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    c  = '0;
    gc = '0;
    for (int k = 0; k < int'(GROUPS); k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    rc_o    = p ^ c;
    c_out_o = gc[GROUPS];
  end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle signed/unsigned 32-bit divider (DIV/DIVU) built around one
// shared adder. Restoring division, one quotient bit per cycle, with
// magnitude conversion before and sign fix-up after the iterations.
//   clock, reset_n          : clock, async active-low reset
//   start, is_signed        : launch request and signedness (sampled when idle)
//   dividend, divisor       : operands (sampled with start)
//   busy                    : operation in flight
//   done                    : one-cycle completion pulse
//   div_by_zero             : divisor was zero (held with results)
//   quotient, remainder     : LO / HI results, held until the next completion
module div_seq_32
  import div_seq_32_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;       // |dividend|, then shifts into the quotient
  logic [DATA_W-1:0] b_q, b_d;       // divisor as sampled
  logic [DATA_W-1:0] dvd_q, dvd_d;   // original dividend for the div-by-zero remainder
  logic [DATA_W-1:0] nd_q, nd_d;     // -|divisor|
  logic [DATA_W-1:0] r_q, r_d;       // partial remainder
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sgn_q, sgn_d;
  logic              sq_q, sq_d;
  logic              sr_q, sr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  div_res_t          res_q, res_d;

  logic [DATA_W-1:0] add_a_c, add_b_c, add_rc_c;
  logic              add_co_c;
  logic [DATA_W-1:0] iter_s_c;

  div_seq_32_add u_add (
    .a_i     (add_a_c),
    .b_i     (add_b_c),
    .rc_o    (add_rc_c),
    .c_out_o (add_co_c)
  );

  // Shifted remainder with the next dividend bit appended
  assign iter_s_c = {r_q[DATA_W-2:0], a_q[DATA_W-1]};

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      nd_q    <= '0;
      r_q     <= '0;
      count_q <= '0;
      sgn_q   <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      nd_q    <= nd_d;
      r_q     <= r_d;
      count_q <= count_d;
      sgn_q   <= sgn_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // Next-state, adder steering and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    nd_d    = nd_q;
    r_d     = r_q;
    count_d = count_q;
    sgn_d   = sgn_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    add_a_c = '0;
    add_b_c = '0;

    case (state_q)
      // DONE accepts a new start exactly like IDLE
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_ABS_A;
          busy_d  = 1'b1;
          a_d     = dividend;
          dvd_d   = dividend;
          b_d     = divisor;
          sgn_d   = is_signed;
          r_d     = '0;
          count_d = '0;
        end
      end

      ST_ABS_A: begin
        add_a_c = ~a_q;
        add_b_c = DATA_W'(1);
        if (sgn_q && a_q[DATA_W-1]) a_d = add_rc_c;
        sq_d    = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        sr_d    = sgn_q & a_q[DATA_W-1];
        state_d = ST_ABS_B;
      end

      ST_ABS_B: begin
        add_a_c = ~b_q;
        add_b_c = DATA_W'(1);
        nd_d    = (sgn_q && b_q[DATA_W-1]) ? b_q : add_rc_c;
        if (b_q == '0) begin
          res_d.quot = DIV0_QUOT;
          res_d.rem  = dvd_q;
          res_d.dbz  = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end

      // Trial subtract: carry out means S >= |divisor|
      ST_ITER: begin
        add_a_c = iter_s_c;
        add_b_c = nd_q;
        if (add_co_c) begin
          r_d = add_rc_c;
          a_d = {a_q[DATA_W-2:0], 1'b1};
        end else begin
          r_d = iter_s_c;
          a_d = {a_q[DATA_W-2:0], 1'b0};
        end
        if (count_q == CNT_W'(ITERS - 1)) begin
          count_d = '0;
          state_d = ST_FIX_Q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      ST_FIX_Q: begin
        add_a_c = ~a_q;
        add_b_c = DATA_W'(1);
        if (sq_q) a_d = add_rc_c;
        state_d = ST_FIX_R;
      end

      // Remainder fix and result capture happen together on entry to DONE
      ST_FIX_R: begin
        add_a_c    = ~r_q;
        add_b_c    = DATA_W'(1);
        if (sr_q) r_d = add_rc_c;
        res_d.quot = a_q;
        res_d.rem  = sr_q ? add_rc_c : r_q;
        res_d.dbz  = 1'b0;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = res_q.dbz;
  assign quotient    = res_q.quot;
  assign remainder   = res_q.rem;

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: transaction-level reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_div_seq_32;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic m_busy;
  logic m_done;
  int   m_left;
  res_t m_res;
  res_t p_res;

  div_seq_32 dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: truncating division, remainder follows dividend
  function automatic res_t ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    res_t            o;
    if (b == 32'd0) begin
      o.q = 32'hFFFF_FFFF;
      o.r = a;
      o.z = 1'b1;
    end else if (s) begin
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      o.q = 32'(sa / sb);
      o.r = 32'(sa % sb);
      o.z = 1'b0;
    end else begin
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      o.q = 32'(ua / ub);
      o.r = 32'(ua % ub);
      o.z = 1'b0;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: accepted when not busy; done 36 cycles later, or 2 for divisor 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      p_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_res  <= p_res;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        p_res  <= ref_div(is_signed, dividend, divisor);
        m_busy <= 1'b1;
        m_left <= (divisor == 32'd0) ? 2 : 36;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always begin
    @(posedge clk);
    #1;
    check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
    check("cyc_dbz",  {31'd0, dbz},  {31'd0, m_res.z});
    check("cyc_quot", quotient, m_res.q);
    check("cyc_rem",  remainder, m_res.r);
  end

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Cycles from the accept edge to the first cycle done is seen high
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 80 cycles at %0t", $time);
    end
  endtask

  task automatic op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input logic ez, input int elat);
    int cyc;
    launch(s, a, b);
    wait_done(cyc);
    check({name, "_lat"}, 32'(cyc), 32'(elat));
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'hFFFF_FFFE;
      6:       return 32'(10'($urandom));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   cyc;
    int   done_seen;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Pin the reference model with hand-computed values
    r = ref_div(1'b1, 32'd100, 32'd7);
    check("model_100_7_q", r.q, 32'd14);
    check("model_100_7_r", r.r, 32'd2);
    r = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model_ovf_q", r.q, 32'h8000_0000);
    r = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
    check("model_neg_r", r.r, 32'hFFFF_FFFE);
    r = ref_div(1'b0, 32'hFFFF_FF9C, 32'd7);
    check("model_u_q", r.q, 32'h2492_4916);

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem",  remainder, 32'd0);
    rst_n = 1'b1;

    // Basic signed, latency 36
    launch(1'b1, 32'd100, 32'd7);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check("s100_7_lat", 32'(cyc), 32'd36);
    check("s100_7_q", quotient, 32'd14);
    check("s100_7_r", remainder, 32'd2);

    op("sn100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 36);
    op("s100_n7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 36);
    op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 36);
    op("u_max_mn", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 36);
    op("u_big_7",  1'b0, 32'hFFFF_FF9C, 32'd7,         32'h2492_4916, 32'd2,         1'b0, 36);
    op("div0",     1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
    op("div0_neg", 1'b1, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 2);
    op("after0",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 36);

    // start pulsed while busy must be ignored
    launch(1'b1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd999;
    divisor  = 32'd3;
    @(negedge clk);
    start    = 1'b0;
    wait_done(cyc);
    check("ign_lat", 32'(cyc), 32'd31);
    check("ign_q", quotient, 32'd14);
    check("ign_r", remainder, 32'd2);

    // Asynchronous reset in the middle of an operation
    launch(1'b0, 32'hFFFF_FF9C, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_dbz",  {31'd0, dbz},  32'd0);
    check("mid_rst_quot", quotient, 32'd0);
    check("mid_rst_rem",  remainder, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);

    // Back-to-back: start held high through the DONE cycle
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(negedge clk);
    dividend  = 32'hFFFF_FF9C;
    wait_done(cyc);
    check("b2b_first_lat", 32'(cyc), 32'd36);
    check("b2b_first_q", quotient, 32'd14);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_second_lat", 32'(cyc), 32'd36);
    check("b2b_second_q", quotient, 32'hFFFF_FFF2);
    check("b2b_second_r", remainder, 32'hFFFF_FFFE);

    // Mixed corner/random sweep; results checked by the per-cycle compare
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      launch(s, a, b);
      wait_done(cyc);
      check("sweep_lat", 32'(cyc), (b == 32'd0) ? 32'd2 : 32'd36);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
